gt_tx_gearbox: RTL
==================

Name: gt_tx_gearbox

Overview:
Parametrised successor to the 3-channel, 2:1 pixel-to-GTH packer. It packs PACK consecutive SYM_W-bit symbols per channel into one GT user word for NUM_CH channels. It runs at the fixed pixel rate, substitutes an idle symbol when the source stalls, and counts underflows. It also emits a registered divided user-clock and a word strobe. It sits between the pixel/TMDS encoder and the transceiver wizard's userdata input.

Parameters:
NUM_CH, 3, number of transceiver channels (1..4)
SYM_W, 10, symbol width per channel per pixel clock
PACK, 2, symbols per GT word per channel; power of two, 2..8
IDLE_SYM, 10'h354, symbol inserted on underflow (width SYM_W)
CNT_W, 16, underflow counter width

Ports:
clk  in  1  pixel clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  gearbox enable (tie to GT tx reset done)
sym_valid  in  1  sym_data valid this cycle
sym_data  in  NUM_CH*SYM_W  channel c at [c*SYM_W +: SYM_W]
underflow_clr  in  1  synchronous clear of underflow_cnt
word_data  out  NUM_CH*PACK*SYM_W  assembled GT word
word_valid  out  1  one-cycle strobe: word_data updated this cycle
usrclk_div  out  1  registered divided clock, period PACK cycles, 50% duty
slot  out  log2(PACK)  current slot index
underflow_cnt  out  CNT_W  saturating count of idle insertions

Behaviour:
- Reset (async assert; release synchronous to clk): slot=0, word_data=0, word_valid=0, usrclk_div=0, underflow_cnt=0, staging register=0.
- Layout: channel c, slot s occupies word bits [(c*PACK+s)*SYM_W +: SYM_W]. Slot 0 is the LSB symbol.
- en=0: slot is held at 0 and usrclk_div at 0. No staging writes, word_valid=0, word_data holds its last value, and underflow_cnt does not count.
- en=1: slot advances every cycle, mod PACK, regardless of sym_valid (fixed-rate GT).
  - Each cycle, staging[slot] for every channel = sym_valid ? sym_data[c] : IDLE_SYM.
- On a cycle with slot==PACK-1 and en=1:
  - The next edge loads word_data from the staging contents, including the symbol written that same cycle.
  - word_valid=1 for exactly that following cycle.
- Latency: the symbol captured in slot s appears on word_data PACK-s cycles later.
- usrclk_div is registered: 1 when the next slot < PACK/2, else 0. For PACK=2 it toggles each cycle, with its rising edge aligned to the cycle slot 0 is sampled.
- Underflow: en=1 and sym_valid=0 increments underflow_cnt by 1, saturating at all-ones.
  - underflow_clr has priority: the counter is 0 the next cycle even if an underflow also occurs.
- en deasserted mid-word: the partial word is discarded and slot is forced to 0 on the next edge. On re-enable, the first word is all fresh symbols.
- reset asserted mid-word: all state returns to reset values immediately.

Optional Feature:
GT_TX_PRBS_EN.
- Defined: adds input prbs_mode (1 bit) and a per-channel PRBS7 (x^7+x^6+1) generator, seeded 7'h7F per channel on reset.
  - prbs_mode=1: each cycle the generator advances SYM_W bits, and its output replaces sym_data/IDLE_SYM in staging.
  - In prbs_mode, underflow counting is suppressed.
- Undefined: no port, no generator; behaviour exactly as above.

Decomposition:
- Package gt_tx_gearbox_pkg: default constants (symbol width, idle symbol 10'h354, PRBS7 taps/seed) and function clog2_min1 for slot width.
- Sub-module gt_tx_lane_packer: one channel's staging register and word slice. Instantiated NUM_CH times via generate.
- PRBS generator stays inline under the macro.

Test Plan:
1. Defaults, en=1, sym_valid=1, r/g/b = 10'h001/002/003 then 10'h004/005/006 -> word_data = {006,003,005,002,004,001} per-channel lanes, word_valid pulse next cycle, underflow_cnt=0.
2. PACK=4, NUM_CH=1, symbols 1,2,3,4 continuous -> word_data=40'h004_003_002_001 one cycle after slot 3; usrclk_div pattern 1,1,0,0 repeating.
3. sym_valid=0 in slot 1 only -> that slot holds 10'h354 in all channels, underflow_cnt=1. Then underflow_clr together with another underflow -> 0.
4. CNT_W=4, 20 consecutive underflows -> underflow_cnt saturates at 4'hF.
5. en dropped at slot 1 of PACK=4, restored 3 cycles later -> no word_valid while low; the first word after restore contains only post-restore symbols.
6. Async reset asserted between clock edges mid-word -> all outputs 0 immediately. With GT_TX_PRBS_EN, prbs_mode=1 -> first lane-0 symbol matches the reference PRBS7 sequence from seed 7'h7F.

Source files
------------

// File: rtl/gt_tx_gearbox_pkg.sv
// gt_tx_gearbox_pkg: shared defaults, symbol-source encoding, PRBS7 constants
// and the slot-width helper for the transceiver TX gearbox.
package gt_tx_gearbox_pkg;

  localparam int DEF_NUM_CH = 3;
  localparam int DEF_SYM_W  = 10;
  localparam int DEF_PACK   = 2;
  localparam int DEF_CNT_W  = 16;

  // Idle symbol substituted whenever the pixel source stalls.
  localparam logic [9:0] DEF_IDLE_SYM = 10'h354;

  // PRBS7 polynomial x^7 + x^6 + 1: feedback taps are state bits 6 and 5.
  localparam int         PRBS_W     = 7;
  localparam int         PRBS_TAP_A = 6;
  localparam int         PRBS_TAP_B = 5;
  localparam logic [6:0] PRBS_SEED  = 7'h7F;

  // Where the staged symbol of a lane comes from in a given cycle.
  typedef enum logic [1:0] {
    SYM_SRC_DATA = 2'd0,
    SYM_SRC_IDLE = 2'd1,
    SYM_SRC_PRBS = 2'd2
  } sym_src_e;

  // Bits needed to index 'value' slots; never less than one so the slot
  // port always exists.
  function automatic int clog2_min1(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      if (int'(32'd1 << i) < value) begin
        width = i + 1;
      end else begin
        width = width;
      end
    end
    return width;
  endfunction

endpackage

// File: rtl/gt_tx_lane_packer.sv
// gt_tx_lane_packer: one channel's staging register and GT word slice.
// The completing word includes the symbol presented in the last slot, so the
// current symbol is overlaid onto the staging contents before both registers
// load.
module gt_tx_lane_packer
  import gt_tx_gearbox_pkg::*;
#(
  parameter int SYM_W  = DEF_SYM_W,
  parameter int PACK   = DEF_PACK,
  parameter int SLOT_W = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    load,
  input  logic [SLOT_W-1:0]       slot,
  input  logic [SYM_W-1:0]        sym,
  output logic [PACK*SYM_W-1:0]   word
);

  logic [PACK*SYM_W-1:0] staging_r;
  logic [PACK*SYM_W-1:0] merged_s;
  logic [PACK*SYM_W-1:0] word_r;

  // Overlay this cycle's symbol onto its slot of the staged word
  always_comb begin
    merged_s = staging_r;
    for (int s = 0; s < PACK; s++) begin
      if (slot == SLOT_W'(s)) begin
        merged_s[s*SYM_W +: SYM_W] = sym;
      end else begin
        merged_s[s*SYM_W +: SYM_W] = staging_r[s*SYM_W +: SYM_W];
      end
    end
  end

  // Staging register and the registered word slice handed to the GT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staging_r <= '0;
      word_r    <= '0;
    end else begin
      if (en) begin
        staging_r <= merged_s;
      end else begin
        staging_r <= staging_r;
      end
      if (en && load) begin
        word_r <= merged_s;
      end else begin
        word_r <= word_r;
      end
    end
  end

  assign word = word_r;

endmodule

// File: rtl/gt_tx_gearbox.sv
// gt_tx_gearbox: packs PACK consecutive SYM_W-bit symbols per channel into
// one GT user word for NUM_CH channels at the fixed pixel rate, inserting
// IDLE_SYM on source stalls and counting those insertions. Also produces a
// registered divided user clock and a word strobe.
// Optional build macro GT_TX_PRBS_EN adds a prbs_mode input and a per-channel
// PRBS7 generator whose output replaces the staged symbols.
module gt_tx_gearbox
  import gt_tx_gearbox_pkg::*;
#(
  parameter int               NUM_CH   = DEF_NUM_CH,
  parameter int               SYM_W    = DEF_SYM_W,
  parameter int               PACK     = DEF_PACK,
  parameter logic [SYM_W-1:0] IDLE_SYM = SYM_W'(DEF_IDLE_SYM),
  parameter int               CNT_W    = DEF_CNT_W,
  localparam int              SLOT_W   = clog2_min1(PACK)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          sym_valid,
  input  logic [NUM_CH*SYM_W-1:0]       sym_data,
`ifdef GT_TX_PRBS_EN
  input  logic                          prbs_mode,
`endif
  input  logic                          underflow_clr,
  output logic [NUM_CH*PACK*SYM_W-1:0]  word_data,
  output logic                          word_valid,
  output logic                          usrclk_div,
  output logic [SLOT_W-1:0]             slot,
  output logic [CNT_W-1:0]              underflow_cnt
);

  logic [SLOT_W-1:0] slot_r;
  logic [SLOT_W-1:0] slot_next_s;
  logic              last_slot_s;
  logic              word_load_s;
  logic              word_valid_r;
  logic              usrclk_r;
  logic [CNT_W-1:0]  underflow_cnt_r;
  logic              underflow_s;
  logic              prbs_active_s;
  sym_src_e          src_s;

`ifdef GT_TX_PRBS_EN
  assign prbs_active_s = prbs_mode;
`else
  assign prbs_active_s = 1'b0;
`endif

  assign last_slot_s = (slot_r == SLOT_W'(PACK - 1));
  assign word_load_s = en && last_slot_s;

  // Next slot: free-running modulo PACK while enabled, parked at 0 otherwise
  always_comb begin
    if (!en) begin
      slot_next_s = '0;
    end else if (last_slot_s) begin
      slot_next_s = '0;
    end else begin
      slot_next_s = slot_r + SLOT_W'(1);
    end
  end

  // Pick the symbol source shared by all lanes and flag idle insertions
  always_comb begin
    if (prbs_active_s) begin
      src_s = SYM_SRC_PRBS;
    end else if (sym_valid) begin
      src_s = SYM_SRC_DATA;
    end else begin
      src_s = SYM_SRC_IDLE;
    end
    underflow_s = en && !sym_valid && !prbs_active_s;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SYM_W-1:0] lane_sym_s;

`ifdef GT_TX_PRBS_EN
    logic [PRBS_W-1:0]       prbs_state_r;
    logic [PRBS_W+SYM_W-1:0] prbs_run_s;
    logic [PRBS_W-1:0]       prbs_next_s;
    logic [SYM_W-1:0]        prbs_sym_s;

    // Advance PRBS7 by SYM_W bits; the first generated bit lands in the LSB
    function automatic logic [PRBS_W+SYM_W-1:0] prbs7_run(input logic [PRBS_W-1:0] state_in);
      logic [PRBS_W-1:0] st;
      logic [SYM_W-1:0]  sym;
      logic              fb;
      st  = state_in;
      sym = '0;
      for (int i = 0; i < SYM_W; i++) begin
        fb     = st[PRBS_TAP_A] ^ st[PRBS_TAP_B];
        st     = {st[PRBS_W-2:0], fb};
        sym[i] = fb;
      end
      return {st, sym};
    endfunction

    // Compute this cycle's PRBS symbol and the state after it
    always_comb begin
      prbs_run_s  = prbs7_run(prbs_state_r);
      prbs_next_s = prbs_run_s[PRBS_W+SYM_W-1:SYM_W];
      prbs_sym_s  = prbs_run_s[SYM_W-1:0];
    end

    // PRBS7 state: seeded on reset, stepping only while generating
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        prbs_state_r <= PRBS_SEED;
      end else if (en && prbs_mode) begin
        prbs_state_r <= prbs_next_s;
      end else begin
        prbs_state_r <= prbs_state_r;
      end
    end
`endif

    // Select this lane's staged symbol from pixel data, idle or PRBS
    always_comb begin
      case (src_s)
        SYM_SRC_DATA: lane_sym_s = sym_data[c*SYM_W +: SYM_W];
`ifdef GT_TX_PRBS_EN
        SYM_SRC_PRBS: lane_sym_s = prbs_sym_s;
`endif
        SYM_SRC_IDLE: lane_sym_s = IDLE_SYM;
        default:      lane_sym_s = IDLE_SYM;
      endcase
    end

    gt_tx_lane_packer #(
      .SYM_W  (SYM_W),
      .PACK   (PACK),
      .SLOT_W (SLOT_W)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .load  (word_load_s),
      .slot  (slot_r),
      .sym   (lane_sym_s),
      .word  (word_data[c*PACK*SYM_W +: PACK*SYM_W])
    );
  end

  // Slot counter, word strobe and divided user clock (high for the first half of the slots)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_r       <= '0;
      word_valid_r <= 1'b0;
      usrclk_r     <= 1'b0;
    end else begin
      slot_r       <= slot_next_s;
      word_valid_r <= word_load_s;
      usrclk_r     <= en && (slot_next_s < SLOT_W'(PACK / 2));
    end
  end

  // Saturating idle-insertion counter; a clear wins over a same-cycle underflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underflow_cnt_r <= '0;
    end else if (underflow_clr) begin
      underflow_cnt_r <= '0;
    end else if (underflow_s && (underflow_cnt_r != {CNT_W{1'b1}})) begin
      underflow_cnt_r <= underflow_cnt_r + CNT_W'(1);
    end else begin
      underflow_cnt_r <= underflow_cnt_r;
    end
  end

  assign slot          = slot_r;
  assign word_valid    = word_valid_r;
  assign usrclk_div    = usrclk_r;
  assign underflow_cnt = underflow_cnt_r;

endmodule
